// File: rtl/hyperbus_burst_ctrl.sv
// hyperbus_burst_ctrl: HyperBus protocol engine with linear bursts, masked
// writes, zero-latency register writes, fixed/variable latency and read timeout.
module hyperbus_burst_ctrl #(
    parameter int WIDTH         = 8,
    parameter int TACC_COUNT    = 7,
    parameter int MAX_BURST     = 16,
    parameter int FIXED_LATENCY = 0,
    parameter int TIMEOUT       = 63,
    localparam int LW           = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_rw,
    input  logic               cmd_reg,
    input  logic [31:0]        cmd_adr,
    input  logic [LW-1:0]      cmd_len,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic [1:0]         wr_mask,
    output logic               wr_ready,
    output logic [2*WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               ck_en,
    output logic               csn,
    output logic [2*WIDTH-1:0] dq_o,
    output logic               dq_oe,
    input  logic [2*WIDTH-1:0] dq_i,
    input  logic               dq_i_valid,
    output logic [1:0]         rwds_o,
    output logic               rwds_oe,
    input  logic [1:0]         rwds_i
);

    localparam int DW  = 2 * WIDTH;
    localparam int LTW = $clog2(2 * TACC_COUNT + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [LTW-1:0] LAT1 = LTW'(TACC_COUNT - 1);
    localparam logic [LTW-1:0] LAT2 = LTW'(2 * TACC_COUNT - 1);
    localparam logic [LW-1:0]  LMAX = LW'(MAX_BURST);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LAT,
        S_WRITE,
        S_READ,
        S_END,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [47:0]     ca_q, ca_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   wcnt_q, wcnt_d;
    logic [LTW-1:0]  lcnt_q, lcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            lat2_q, lat2_d;
    logic            error_q, error_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;

    logic [LW-1:0]   len_in;
    logic            is_regwr;
    logic            last_word;

    always_comb begin
        len_in = cmd_len;
        if (cmd_len == '0) begin
            len_in = LW'(1);
        end else if (cmd_len > LMAX) begin
            len_in = LMAX;
        end
        // Register writes carry exactly one word.
        if (!cmd_rw && cmd_reg) begin
            len_in = LW'(1);
        end
    end

    assign is_regwr  = !ca_q[47] && ca_q[46];
    assign last_word = (wcnt_q + LW'(1)) == len_q;

    always_comb begin
        state_d    = state_q;
        ca_d       = ca_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        lcnt_d     = lcnt_q;
        tcnt_d     = tcnt_q;
        lat2_d     = lat2_q;
        error_d    = error_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        csn        = 1'b0;
        ck_en      = 1'b1;
        dq_oe      = 1'b0;
        dq_o       = '0;
        rwds_oe    = 1'b0;
        rwds_o     = '0;
        wr_ready   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                csn       = 1'b1;
                ck_en     = 1'b0;
                if (cmd_valid) begin
                    state_d = S_CMD;
                    ca_d    = {cmd_rw, cmd_reg, 1'b1, cmd_adr[31:3],
                               13'd0, cmd_adr[2:0]};
                    len_d   = len_in;
                    lcnt_d  = '0;
                    error_d = 1'b0;
                end
            end
            S_CMD: begin
                dq_oe  = 1'b1;
                lcnt_d = lcnt_q + LTW'(1);
                if (lcnt_q == '0) begin
                    dq_o   = DW'(ca_q[47:32]);
                    lat2_d = (FIXED_LATENCY != 0) || (rwds_i != '0);
                end else if (lcnt_q == LTW'(1)) begin
                    dq_o = DW'(ca_q[31:16]);
                end else begin
                    dq_o = DW'(ca_q[15:0]);
                end
                if (lcnt_q == LTW'(2)) begin
                    wcnt_d = '0;
                    if (is_regwr) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_LAT;
                        lcnt_d  = lat2_q ? LAT2 : LAT1;
                    end
                end
            end
            S_LAT: begin
                lcnt_d = lcnt_q - LTW'(1);
                if (lcnt_q == '0) begin
                    tcnt_d  = TMAX;
                    state_d = ca_q[47] ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                dq_oe    = 1'b1;
                wr_ready = 1'b1;
                dq_o     = wr_data;
                rwds_o   = wr_mask;
                rwds_oe  = !is_regwr;
                wcnt_d   = wcnt_q + LW'(1);
                if (last_word) begin
                    state_d = S_END;
                end
            end
            S_READ: begin
                // A valid word wins over an expiring timeout.
                if (dq_i_valid) begin
                    rd_data_d  = dq_i;
                    rd_valid_d = 1'b1;
                    wcnt_d     = wcnt_q + LW'(1);
                    tcnt_d     = TMAX;
                    if (last_word) begin
                        state_d = S_END;
                    end
                end else if (tcnt_q == '0) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            S_END, S_ERR: begin
                csn     = 1'b1;
                ck_en   = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ca_q       <= '0;
            len_q      <= '0;
            wcnt_q     <= '0;
            lcnt_q     <= '0;
            tcnt_q     <= '0;
            lat2_q     <= 1'b0;
            error_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ca_q       <= ca_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            lcnt_q     <= lcnt_d;
            tcnt_q     <= tcnt_d;
            lat2_q     <= lat2_d;
            error_q    <= error_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign error    = error_q;

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// tb_hyperbus_burst_ctrl: directed vector table plus randomized transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_hyperbus_burst_ctrl;

    localparam int TACC = 7;
    localparam int MAXB = 16;
    localparam int TOUT = 63;
    localparam int NT   = 2048;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_rw, cmd_reg;
    logic [31:0] cmd_adr;
    logic [4:0]  cmd_len;
    logic [15:0] wr_data, rd_data, dq_o, dq_i;
    logic [1:0]  wr_mask, rwds_o, rwds_i;
    logic        wr_ready, rd_valid, busy, done, error;
    logic        ck_en, csn, dq_oe, dq_i_valid, rwds_oe;

    int nerr = 0;
    int nchk = 0;
    bit last_to = 1'b0;

    bit          phy_v[NT];
    logic [15:0] phy_d[NT];
    bit          cap_v[NT];
    logic [15:0] cap_d[NT];

    typedef struct {
        string       nm;
        bit          rw;
        bit          rg;
        logic [31:0] adr;
        logic [4:0]  clen;
        logic [1:0]  r0;
        int          phy;
        logic [47:0] eca;
        int          elen;
        int          elat;
        bit          eto;
    } vec_t;

    vec_t vq[$];

    hyperbus_burst_ctrl dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_reg(cmd_reg),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .error(error),
        .ck_en(ck_en), .csn(csn),
        .dq_o(dq_o), .dq_oe(dq_oe),
        .dq_i(dq_i), .dq_i_valid(dq_i_valid),
        .rwds_o(rwds_o), .rwds_oe(rwds_oe), .rwds_i(rwds_i)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int ref_len(bit rw, bit rg, logic [4:0] cl);
        if (!rw && rg) return 1;
        if (cl == 5'd0) return 1;
        if (int'(cl) > MAXB) return MAXB;
        return int'(cl);
    endfunction

    function automatic int ref_lat(bit rw, bit rg, logic [1:0] r0);
        if (!rw && rg) return 0;
        return (r0 != 2'd0) ? 2 * TACC : TACC;
    endfunction

    function automatic logic [47:0] ref_ca(bit rw, bit rg, logic [31:0] a);
        return {rw, rg, 1'b1, a[31:3], 13'd0, a[2:0]};
    endfunction

    // PHY schedules: 0 ramp every cycle, 1 silent, 2 random,
    // 3 one word then a 63-cycle gap, 4 one word then a 64-cycle gap.
    task automatic fill_phy(input int kind, input int lat);
        for (int i = 0; i < NT; i++) begin
            phy_d[i] = 16'($urandom);
            if (kind == 0) begin
                phy_v[i] = 1'b1;
                phy_d[i] = 16'hA000 + 16'(i);
            end else if (kind == 1) begin
                phy_v[i] = 1'b0;
            end else if (kind == 2) begin
                phy_v[i] = ($urandom_range(3, 0) != 0);
            end else if (kind == 3) begin
                phy_v[i] = !(i > lat && i <= lat + 63);
            end else begin
                phy_v[i] = !(i > lat && i <= lat + 64);
            end
        end
    endtask

    task automatic run_txn(input string nm, input bit rw, input bit rg,
                           input logic [31:0] adr, input logic [4:0] clen,
                           input logic [1:0] r0, input logic [47:0] eca,
                           input int elen, input int elat, input bit spam);
        int          tend;
        int          cnt;
        int          gap;
        bit          to;
        bit          inwin;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic [9:0]  e;
        logic [9:0]  ctl;

        for (int i = 0; i < NT; i++) begin
            cap_v[i] = 1'b0;
            cap_d[i] = '0;
        end
        to   = 1'b0;
        tend = -1;
        if (!rw) begin
            tend = elat + elen;
        end else begin
            cnt = 0;
            gap = 0;
            for (int t = elat; tend < 0 && t < NT - 1; t++) begin
                if (phy_v[t]) begin
                    cap_v[t+1] = 1'b1;
                    cap_d[t+1] = phy_d[t];
                    cnt++;
                    gap = 0;
                    if (cnt == elen) tend = t + 1;
                end else begin
                    gap++;
                    if (gap == TOUT + 1) begin
                        tend = t + 1;
                        to   = 1'b1;
                    end
                end
            end
            if (tend < 0) tend = NT - 2;
        end

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_reg   = rg;
        cmd_adr   = adr;
        cmd_len   = clen;
        rwds_i    = r0;
        @(negedge clk);
        chk({nm, " idle error"}, 32'(error), 32'(last_to));
        chk({nm, " idle ready"}, 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        cmd_valid = spam;
        cmd_rw    = 1'($urandom);
        cmd_reg   = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_len   = 5'($urandom);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) rwds_i = 2'($urandom);
            @(negedge clk);
            ctl = {cmd_ready, busy, csn, ck_en, dq_oe, rwds_oe,
                   wr_ready, rd_valid, done, error};
            chk({nm, " ca ctl"}, 32'(ctl), 32'(10'b0101100000));
            chk({nm, " ca word"}, 32'(dq_o), 32'(eca[47-16*c -: 16]));
            @(posedge clk); #1;
        end

        for (int t = 0; t <= tend + 1; t++) begin
            dq_i_valid = phy_v[t];
            dq_i       = phy_d[t];
            wd         = 16'($urandom);
            wm         = 2'($urandom);
            wr_data    = wd;
            wr_mask    = wm;
            rwds_i     = 2'($urandom);
            cmd_valid  = spam && (t < tend);
            @(negedge clk);
            inwin = !rw && t >= elat && t < tend;
            if (t < tend) begin
                e = {1'b0, 1'b1, 1'b0, 1'b1, inwin, inwin && !rg,
                     inwin, cap_v[t], 1'b0, 1'b0};
            end else if (t == tend) begin
                e = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, cap_v[t], 1'b1, to};
            end else begin
                e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, to};
            end
            ctl = {cmd_ready, busy, csn, ck_en, dq_oe, rwds_oe,
                   wr_ready, rd_valid, done, error};
            chk({nm, " ctl"}, 32'(ctl), 32'(e));
            if (inwin) begin
                chk({nm, " wr dq_o"}, 32'(dq_o), 32'(wd));
                chk({nm, " wr rwds_o"}, 32'(rwds_o), 32'(wm));
            end
            if (cap_v[t]) begin
                chk({nm, " rd_data"}, 32'(rd_data), 32'(cap_d[t]));
            end
            if (t < tend + 1) begin
                @(posedge clk); #1;
            end
        end
        dq_i_valid = 1'b0;
        cmd_valid  = 1'b0;
        last_to    = to;
    endtask

    task automatic addv(input string nm, input bit rw, input bit rg,
                        input logic [31:0] adr, input logic [4:0] clen,
                        input logic [1:0] r0, input int phy,
                        input logic [47:0] eca, input int elen,
                        input int elat, input bit eto);
        vec_t v;
        v.nm   = nm;
        v.rw   = rw;
        v.rg   = rg;
        v.adr  = adr;
        v.clen = clen;
        v.r0   = r0;
        v.phy  = phy;
        v.eca  = eca;
        v.elen = elen;
        v.elat = elat;
        v.eto  = eto;
        vq.push_back(v);
    endtask

    initial begin
        cmd_valid  = 1'b0;
        cmd_rw     = 1'b0;
        cmd_reg    = 1'b0;
        cmd_adr    = '0;
        cmd_len    = '0;
        wr_data    = '0;
        wr_mask    = '0;
        dq_i       = '0;
        dq_i_valid = 1'b0;
        rwds_i     = '0;

        addv("rd4",      1, 0, 32'h0000_1235, 5'd4,  2'd0, 0,
             48'hA000_0246_0005, 4, 7, 0);
        addv("rd4lat2",  1, 0, 32'h0000_1235, 5'd4,  2'd3, 0,
             48'hA000_0246_0005, 4, 14, 0);
        addv("wr3",      0, 0, 32'h0000_0040, 5'd3,  2'd0, 2,
             48'h2000_0008_0000, 3, 7, 0);
        addv("regwr",    0, 1, 32'hFFFF_FFFF, 5'd5,  2'd3, 2,
             48'h7FFF_FFFF_0007, 1, 0, 0);
        addv("rdstuck",  1, 0, 32'h0000_0008, 5'd2,  2'd0, 1,
             48'hA000_0001_0000, 2, 7, 1);
        addv("rdlen0",   1, 0, 32'h0000_0003, 5'd0,  2'd0, 0,
             48'hA000_0000_0003, 1, 7, 0);
        addv("rdlen31",  1, 0, 32'h0000_0010, 5'd31, 2'd1, 0,
             48'hA000_0002_0000, 16, 14, 0);
        addv("regrd",    1, 1, 32'h0000_0000, 5'd2,  2'd0, 2,
             48'hE000_0000_0000, 2, 7, 0);
        addv("wr16lat2", 0, 0, 32'h0000_0007, 5'd16, 2'd2, 2,
             48'h2000_0000_0007, 16, 14, 0);
        addv("gap63",    1, 0, 32'h0000_0020, 5'd3,  2'd0, 3,
             48'hA000_0004_0000, 3, 7, 0);
        addv("gap64",    1, 0, 32'h0000_0020, 5'd3,  2'd0, 4,
             48'hA000_0004_0000, 3, 7, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ctl",
            32'({busy, csn, ck_en, dq_oe, rwds_oe, wr_ready,
                 rd_valid, done, error}), 32'(9'b010000000));
        chk("reset dq_o", 32'(dq_o), 32'(0));
        chk("reset rwds_o", 32'(rwds_o), 32'(0));
        rstn = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(cmd_ready), 32'(1));

        foreach (vq[i]) begin
            fill_phy(vq[i].phy, vq[i].elat);
            run_txn(vq[i].nm, vq[i].rw, vq[i].rg, vq[i].adr, vq[i].clen,
                    vq[i].r0, vq[i].eca, vq[i].elen, vq[i].elat,
                    (i % 2) == 1);
            chk({vq[i].nm, " final error"}, 32'(error), 32'(vq[i].eto));
        end

        for (int n = 0; n < 40; n++) begin
            bit          rw;
            bit          rg;
            logic [31:0] a;
            logic [4:0]  cl;
            logic [1:0]  r0;
            int          k;
            int          kind;
            int          el;
            int          lt;
            rw = 1'($urandom);
            rg = ($urandom_range(3, 0) == 0);
            a  = $urandom;
            cl = 5'($urandom);
            r0 = ($urandom_range(1, 0) == 0) ? 2'd0
                                             : 2'($urandom_range(3, 1));
            el = ref_len(rw, rg, cl);
            lt = ref_lat(rw, rg, r0);
            k  = $urandom_range(9, 0);
            kind = (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 4
                 : (k == 3) ? 0 : 2;
            fill_phy(kind, lt);
            run_txn("rnd", rw, rg, a, cl, r0, ref_ca(rw, rg, a),
                    el, lt, (n % 2) == 1);
        end

        fill_phy(0, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_reg   = 1'b0;
        cmd_adr   = 32'h0000_0100;
        cmd_len   = 5'd4;
        rwds_i    = 2'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        dq_i_valid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("midlat reset",
            32'({csn, busy, ck_en, dq_oe, done}), 32'(5'b10000));
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post reset idle",
                32'({cmd_ready, busy, csn, done, rd_valid, error}),
                32'(6'b101000));
        end
        dq_i_valid = 1'b0;
        last_to    = 1'b0;

        fill_phy(vq[0].phy, vq[0].elat);
        run_txn("recover", vq[0].rw, vq[0].rg, vq[0].adr, vq[0].clen,
                vq[0].r0, vq[0].eca, vq[0].elen, vq[0].elat, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
